sipo_frame_ctrl: RTL
====================

Name: sipo_frame_ctrl

Overview:
- Controller that sequences an internal WIDTH-bit serial-in/parallel-out shift register to receive framed serial words: one start bit (0), WIDTH data bits LSB-first, one stop bit (1).
- Serial bits are sampled only on a bit-rate strobe.
- Completed words go to a holding register with a valid/ready handshake toward the downstream consumer.
- Sits between the serial line front end and any parallel consumer in the datapath.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the internal bit counter; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit-rate strobe; serial_in is sampled only in cycles where bit_en=1.
- serial_in  input  1  serial line; idle level is 1.
- data_out  output  WIDTH  holding register containing the last good word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  one-cycle pulse when a good frame is dropped because the holding register is full.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-frame):
  - state=IDLE; shift register, bit counter and data_out clear to 0.
  - data_valid, busy, frame_err and overrun clear to 0.
  - Any partial frame is discarded.
- FSM states: IDLE, DATA, STOP. All transitions happen only in bit_en=1 cycles. With bit_en=0, state, counter and shift register hold.
- IDLE:
  - serial_in=0 sampled: go to DATA, counter=0.
  - serial_in=1: stay in IDLE.
  - No start-bit mid-sample validation.
- DATA:
  - Each sampled bit: shift register <= {serial_in, shreg[WIDTH-1:1]} (new bit enters the MSB and moves toward bit 0, so after WIDTH shifts the first data bit sits at bit 0); counter+1.
  - After the WIDTH-th data bit (counter reaches WIDTH-1 when sampled): go to STOP.
- STOP:
  - serial_in=1 sampled (good frame):
    - If data_valid=0, or data_ready=1 in the same cycle: data_out <= shreg, data_valid=1 next cycle.
    - Else: data_out unchanged, overrun pulses high for 1 cycle.
  - serial_in=0 sampled: frame_err pulses for 1 cycle; shreg discarded; data_out and data_valid unchanged.
  - Either case returns to IDLE. A start bit may be detected on the very next bit_en strobe (no extra idle bit required).
- Handshake:
  - data_valid stays high and data_out stays stable until a cycle with data_ready=1.
  - Acceptance without a simultaneous new word clears data_valid next cycle.
  - Simultaneous accept and load: data_valid stays 1, data_out takes the new word, no overrun.
  - data_ready while data_valid=0 is ignored.
- busy = (state != IDLE), registered with the state.
- Latency: data_valid rises on the edge following the bit_en cycle that samples the stop bit.
- frame_err and overrun are mutually exclusive and never high for two consecutive cycles.

Test Plan:
- WIDTH=8, bit_en=1 every 4th cycle, send start, data bits 1,0,1,0,0,1,0,1, then stop=1 -> data_out=8'hA5, data_valid=1 one cycle after the stop sample; busy=0 at the same time; data_ready=1 clears data_valid next cycle.
- Send 8'h3C with stop bit 0 -> frame_err single-cycle pulse; data_valid stays 0; data_out stays 8'h00; next frame 8'h81 received correctly.
- Receive 8'h11 and hold data_ready=0, then receive 8'h22 -> overrun pulses once; data_out stays 8'h11; after accept, data_valid=0.
- Receive 8'h11, then assert data_ready exactly in the stop-bit cycle of 8'h22 -> data_valid stays 1, data_out=8'h22, no overrun.
- Assert rst for 1 cycle after the 4th data bit of 8'hFF -> all outputs 0, state IDLE; next full frame 8'h5A is received correctly with no stale bits.
- Back-to-back frames 8'h00 then 8'hFF with no idle bits, bit_en held at 1 -> both words delivered in order with consumer data_ready=1; no frame_err or overrun.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start(0), WIDTH data bits LSB-first, stop(1), sampled on bit_en.
// Completed words are parked in a holding register offered downstream via data_valid/data_ready.
module sipo_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    vld_d   = vld_q & ~data_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in) begin
            // A same-cycle accept frees the holding register for the new word.
            if (!vld_q || data_ready) begin
              data_d = shreg_q;
              vld_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = vld_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
